lab3_mem_line_mem_responder: RTL and testbench
==============================================

# lab3_mem_line_mem_responder

Cache-line memory responder: the memory-side end of the 16B memory request/response interface driven by the blocking cache. Accepts one `mem_req_16B_t` per handshake, performs a READ, WRITE or INIT against an internal line array, and returns a `mem_resp_16B_t` after a configurable latency. Used as the backing memory in cache unit tests and in the composed cache-plus-memory system.

## Interface
- `p_num_lines`, 256: number of 128-bit lines stored; power of two, ≥2.
- `p_latency`, 0: extra wait cycles between request accept and response valid; 0..15.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `memreq_val` in 1: request valid.
- `memreq_rdy` out 1: responder can accept a request.
- `memreq_msg` in `mem_req_16B_t`: type_, opaque, addr, len, data.
- `memresp_val` out 1: response valid.
- `memresp_rdy` in 1: consumer accepts response.
- `memresp_msg` out `mem_resp_16B_t`: type_, opaque, test, len, data.

## Operation
- Line index = `addr[4+$clog2(p_num_lines)-1:4]`; higher address bits ignored (address wraps modulo array size). Byte offset `off = addr[3:0]`; byte count `n = (len==0) ? 16 : len`.
- Legal request: `off + n <= 16`. Illegal request: treated as if `n = 16 - off` (truncate at line end); no error signalled.
- READ (3'd0): response data = bytes `off..off+n-1` of the line placed at data bytes `0..n-1`; upper bytes zero. len echoed.
- WRITE (3'd1) and INIT (3'd2): request data bytes `0..n-1` written to line bytes `off..off+n-1`; other bytes unchanged. Response data = 0; len echoed. INIT and WRITE differ only in echoed type_.
- Any other type_: no array update; response data = 0, type_ echoed.
- Response always echoes opaque; test = 2'b00.
- Array contents are not cleared by reset; benches must INIT before reading.
- FSM states:
  - IDLE: `memreq_rdy=1`. On accept, latch request. If `p_latency==0` → RESP, else load counter with `p_latency` → WAIT.
  - WAIT: counter decrements each cycle; when it reaches 1 → RESP.
  - RESP: `memresp_val=1`. On `memresp_rdy`: if `memreq_val` (rdy also 1 here), accept the next request as in IDLE; else → IDLE.
- Array access (read capture into response register, or write) happens on the clock edge entering RESP, so a READ following a WRITE to the same line returns the written data.
- `memreq_rdy = (state==IDLE) || (state==RESP && memresp_rdy)`; combinational from state and `memresp_rdy` only, never from `memreq_val`.

## Timing
- Reset asserted (low): state → IDLE, counter → 0, `memresp_val=0`, `memresp_msg=0`, `memreq_rdy=0` while reset is low; `memreq_rdy=1` from the first cycle after release.
- Request accepted at edge t (val&&rdy) → `memresp_val` high from cycle t+1+p_latency.
- Response held stable while `memresp_val && !memresp_rdy`; it may stall indefinitely; no further requests are accepted meanwhile.
- Back-to-back throughput with `p_latency=0` and `memresp_rdy` held high: one transaction per cycle.
- Reset mid-transaction: pending request and response are discarded; any write not yet performed is lost; a write performed earlier persists.

## Configuration
- `LAB3_MEM_RESP_STALL_EN`: when defined, a 16-bit LFSR (seed 16'hACE1 on reset, advances each cycle) gates response presentation: in RESP, `memresp_val` is asserted only when LFSR bit 0 is 1; the message is held meanwhile and the back-to-back path only fires on cycles where `memresp_val` is high. Without it, `memresp_val` follows state exactly and latency is deterministic as in Timing.

## Test plan
- INIT addr 0x100 data 0x0f0e..0100 len 0, then READ addr 0x100 len 0 opaque 0x3a → response type 0, opaque 0x3a, data 0x0f0e0d0c_0b0a0908_07060504_03020100, test 0.
- WRITE addr 0x108 len 4 data 0xdeadbeef over that line, then READ addr 0x100 len 0 → data 0x0f0e0d0c_deadbeef_07060504_03020100; READ addr 0x108 len 4 → data 0x00000000_00000000_00000000_deadbeef.
- `p_latency=3`: accept at cycle 10 → `memresp_val` first high at cycle 14; hold `memresp_rdy=0` for 5 cycles → message unchanged, `memreq_rdy=0`.
- `p_latency=0`, `memreq_val` and `memresp_rdy` high continuously for 8 READs → 8 responses in 8 consecutive cycles, opaques in order.
- Wrap-around with `p_num_lines=16`: WRITE addr 0x0000_0010, READ addr 0x0000_0110 → same line data returned.
- Assert reset low during WAIT → `memresp_val=0` immediately, `memreq_rdy=1` the cycle after release, no response for the discarded request.

Source files
------------

// File: rtl/lab3_mem_line_mem_responder_if.sv
// Message types and the request/response handshake bundle for the 16B line memory port.
package lab3_mem_line_mem_responder_pkg;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [31:0]  addr;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_req_16B_t;

  typedef struct packed {
    logic [2:0]   type_;
    logic [7:0]   opaque;
    logic [1:0]   test;
    logic [3:0]   len;
    logic [127:0] data;
  } mem_resp_16B_t;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

endpackage

interface lab3_mem_line_mem_responder_if;
  import lab3_mem_line_mem_responder_pkg::*;

  logic          memreq_val;
  logic          memreq_rdy;
  mem_req_16B_t  memreq_msg;
  logic          memresp_val;
  logic          memresp_rdy;
  mem_resp_16B_t memresp_msg;

  modport master (
    output memreq_val, memreq_msg, memresp_rdy,
    input  memreq_rdy, memresp_val, memresp_msg
  );

  modport slave (
    input  memreq_val, memreq_msg, memresp_rdy,
    output memreq_rdy, memresp_val, memresp_msg
  );

endinterface

// File: rtl/lab3_mem_line_mem_responder.sv
// Line-array memory responder for the 16B cache memory port with fixed response latency.
// Optional LAB3_MEM_RESP_STALL_EN: LFSR-driven random gating of response presentation.
module lab3_mem_line_mem_responder
  import lab3_mem_line_mem_responder_pkg::*;
#(
  parameter int p_num_lines = 256,
  parameter int p_latency   = 0
) (
  input  logic clk,
  input  logic reset,
  lab3_mem_line_mem_responder_if.slave mem
);

  localparam int IDX_W = $clog2(p_num_lines);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  mem_req_16B_t  req_q, req_d;
  mem_resp_16B_t resp_q, resp_d;
  logic [127:0]  mem_q [p_num_lines];

  mem_req_16B_t     cur_req;
  logic             accept, resp_fire, do_access, wr_en;
  logic [IDX_W-1:0] idx;
  logic [4:0]       off, n_bytes;
  logic [3:0]       pos;
  logic [127:0]     line, rd_data, wr_line;
  logic             unused_addr_bits;

`ifdef LAB3_MEM_RESP_STALL_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) lfsr_q <= 16'hACE1;
    else        lfsr_q <= lfsr_d;
  end

  assign mem.memresp_val = (state_q == RESP) && lfsr_q[0];
`else
  assign mem.memresp_val = (state_q == RESP);
`endif

  assign resp_fire       = mem.memresp_val && mem.memresp_rdy;
  assign mem.memreq_rdy  = reset && ((state_q == IDLE) || resp_fire);
  assign accept          = mem.memreq_val && mem.memreq_rdy;
  assign mem.memresp_msg = resp_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    unique case (state_q)
      IDLE: ;
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: if (resp_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      req_d = mem.memreq_msg;
      if (p_latency == 0) begin
        state_d = RESP;
      end else begin
        state_d = WAIT;
        cnt_d   = 4'(p_latency);
      end
    end
  end

  // The array is touched only on the edge that enters RESP; with zero latency that
  // edge is also the accept edge, so the live request is used instead of the latch.
  assign cur_req   = (state_q == WAIT) ? req_q : mem.memreq_msg;
  assign do_access = (state_d == RESP) && ((state_q == WAIT) || accept);
  assign idx       = cur_req.addr[4 +: IDX_W];
  assign unused_addr_bits = ^cur_req.addr[31:4+IDX_W];

  always_comb begin
    off     = {1'b0, cur_req.addr[3:0]};
    n_bytes = (cur_req.len == 4'd0) ? 5'd16 : {1'b0, cur_req.len};
    if (off + n_bytes > 5'd16) n_bytes = 5'd16 - off;
    line    = mem_q[idx];
    rd_data = '0;
    wr_line = line;
    pos     = '0;
    for (int i = 0; i < 16; i++) begin
      pos = off[3:0] + 4'(i);
      if (5'(i) < n_bytes) begin
        rd_data[8*i +: 8]          = line[{pos, 3'b000} +: 8];
        wr_line[{pos, 3'b000} +: 8] = cur_req.data[8*i +: 8];
      end
    end
  end

  always_comb begin
    resp_d = resp_q;
    wr_en  = 1'b0;
    if (do_access) begin
      resp_d.type_  = cur_req.type_;
      resp_d.opaque = cur_req.opaque;
      resp_d.test   = 2'b00;
      resp_d.len    = cur_req.len;
      resp_d.data   = '0;
      case (cur_req.type_)
        MEM_READ:            resp_d.data = rd_data;
        MEM_WRITE, MEM_INIT: wr_en = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      resp_q  <= resp_d;
    end
  end

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[idx] <= wr_line;
  end

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Self-checking bench: a zero-latency instance checked against a byte-array model,
// and a three-cycle-latency instance for timing, stall and reset behaviour.
module tb_lab3_mem_line_mem_responder;
  import lab3_mem_line_mem_responder_pkg::*;

  logic clk = 1'b0;
  logic rst0, rst3;
  int   n_cmp = 0;
  int   n_bad = 0;

  lab3_mem_line_mem_responder_if if0 ();
  lab3_mem_line_mem_responder_if if3 ();

  lab3_mem_line_mem_responder #(.p_num_lines(16), .p_latency(0)) dut0 (
    .clk(clk), .reset(rst0), .mem(if0)
  );
  lab3_mem_line_mem_responder #(.p_num_lines(16), .p_latency(3)) dut3 (
    .clk(clk), .reset(rst3), .mem(if3)
  );

  always #5 clk = ~clk;

  logic [7:0] ref_mem [16][16];

  function automatic mem_req_16B_t mk_req(input logic [2:0] t, input logic [7:0] op,
                                          input logic [31:0] a, input logic [3:0] l,
                                          input logic [127:0] d);
    mem_req_16B_t r;
    r.type_ = t; r.opaque = op; r.addr = a; r.len = l; r.data = d;
    return r;
  endfunction

  function automatic mem_resp_16B_t mk_resp(input logic [2:0] t, input logic [7:0] op,
                                            input logic [3:0] l, input logic [127:0] d);
    mem_resp_16B_t e;
    e.type_ = t; e.opaque = op; e.test = 2'b00; e.len = l; e.data = d;
    return e;
  endfunction

  // Reference: byte-granular line store, truncating requests that run past the line end.
  function automatic mem_resp_16B_t model(input mem_req_16B_t r);
    int off, n, ln;
    mem_resp_16B_t e;
    off = int'(r.addr[3:0]);
    n   = (r.len == 4'd0) ? 16 : int'(r.len);
    if (off + n > 16) n = 16 - off;
    ln  = int'((r.addr >> 4) % 32'd16);
    e   = mk_resp(r.type_, r.opaque, r.len, 128'd0);
    for (int i = 0; i < n; i++) begin
      if (r.type_ == 3'd0)
        e.data[8*i +: 8] = ref_mem[ln][off+i];
      else if (r.type_ == 3'd1 || r.type_ == 3'd2)
        ref_mem[ln][off+i] = r.data[8*i +: 8];
    end
    return e;
  endfunction

  task automatic check_output(input string tag, input logic [175:0] obs, input logic [175:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic apply_txn_fast(input mem_req_16B_t r, output mem_resp_16B_t got);
    mem_resp_16B_t e;
    @(negedge clk);
    if0.memreq_msg  = r;
    if0.memreq_val  = 1'b1;
    if0.memresp_rdy = 1'b1;
    check_output("req_rdy0", 176'(if0.memreq_rdy), 176'(1'b1));
    @(negedge clk);
    if0.memreq_val = 1'b0;
    e = model(r);
    check_output("resp_val0", 176'(if0.memresp_val), 176'(1'b1));
    check_output("resp_msg0", 176'(if0.memresp_msg), 176'(e));
    got = if0.memresp_msg;
  endtask

  // Leaves the response pending (memresp_rdy low); lat counts negedges from accept to valid.
  task automatic apply_txn_slow(input mem_req_16B_t r, output int lat);
    int w;
    @(negedge clk);
    if3.memreq_msg  = r;
    if3.memreq_val  = 1'b1;
    if3.memresp_rdy = 1'b0;
    w = 0;
    while (!if3.memreq_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    check_output("req_rdy3", 176'(if3.memreq_rdy), 176'(1'b1));
    @(negedge clk);
    if3.memreq_val = 1'b0;
    lat = 1;
    while (!if3.memresp_val && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    mem_req_16B_t  r;
    mem_resp_16B_t got;
    mem_resp_16B_t exp_q [8];
    mem_req_16B_t  tp_req;
    logic [127:0]  d;
    logic [2:0]    t;
    int            lat;
    logic          seen;

    rst0 = 1'b0; rst3 = 1'b0;
    if0.memreq_val = 1'b0; if0.memresp_rdy = 1'b0; if0.memreq_msg = '0;
    if3.memreq_val = 1'b0; if3.memresp_rdy = 1'b0; if3.memreq_msg = '0;

    repeat (2) @(negedge clk);
    check_output("rst_req_rdy", 176'(if0.memreq_rdy), 176'(1'b0));
    check_output("rst_resp_val", 176'(if0.memresp_val), 176'(1'b0));
    check_output("rst_resp_msg", 176'(if0.memresp_msg), 176'(0));
    rst0 = 1'b1; rst3 = 1'b1;
    #1;
    check_output("post_rst_rdy0", 176'(if0.memreq_rdy), 176'(1'b1));
    check_output("post_rst_rdy3", 176'(if3.memreq_rdy), 176'(1'b1));

    for (int i = 0; i < 16; i++) begin
      r = mk_req(MEM_INIT, 8'(i), ($urandom & 32'hFFFF_FF00) | 32'(i << 4), 4'd0,
                 {$urandom, $urandom, $urandom, $urandom});
      apply_txn_fast(r, got);
    end

    apply_txn_fast(mk_req(MEM_INIT, 8'h01, 32'h100, 4'd0,
                          128'h0f0e0d0c_0b0a0908_07060504_03020100), got);
    apply_txn_fast(mk_req(MEM_READ, 8'h3a, 32'h100, 4'd0, 128'd0), got);
    check_output("plan_read_init", 176'(got),
                 176'(mk_resp(3'd0, 8'h3a, 4'd0, 128'h0f0e0d0c_0b0a0908_07060504_03020100)));
    apply_txn_fast(mk_req(MEM_WRITE, 8'h02, 32'h108, 4'd4, 128'hdeadbeef), got);
    apply_txn_fast(mk_req(MEM_READ, 8'h03, 32'h100, 4'd0, 128'd0), got);
    check_output("plan_read_merged", 176'(got.data),
                 176'(128'h0f0e0d0c_deadbeef_07060504_03020100));
    apply_txn_fast(mk_req(MEM_READ, 8'h04, 32'h108, 4'd4, 128'd0), got);
    check_output("plan_read_word", 176'(got.data), 176'(128'hdeadbeef));

    // Past-end-of-line request: offset 14 with four bytes keeps only two.
    apply_txn_fast(mk_req(MEM_READ, 8'h05, 32'h10e, 4'd4, 128'd0), got);
    check_output("plan_truncate", 176'(got.data), 176'(128'h0f0e));

    for (int k = 0; k < 40; k++) begin
      t = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
      r = mk_req(t, 8'($urandom), $urandom, 4'($urandom),
                 {$urandom, $urandom, $urandom, $urandom});
      apply_txn_fast(r, got);
    end

    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_output("tp_val", 176'(if0.memresp_val), 176'(1'b1));
        check_output("tp_msg", 176'(if0.memresp_msg), 176'(exp_q[i-1]));
      end
      if (i < 8) begin
        check_output("tp_rdy", 176'(if0.memreq_rdy), 176'(1'b1));
        tp_req = mk_req(MEM_READ, 8'(8'h80 + i), $urandom, 4'($urandom), 128'd0);
        if0.memreq_msg  = tp_req;
        if0.memreq_val  = 1'b1;
        if0.memresp_rdy = 1'b1;
        exp_q[i] = model(tp_req);
      end else begin
        if0.memreq_val = 1'b0;
      end
    end
    @(negedge clk);
    check_output("tp_drain", 176'(if0.memresp_val), 176'(1'b0));

    d = {$urandom, $urandom, $urandom, $urandom};
    apply_txn_fast(mk_req(MEM_WRITE, 8'h10, 32'h0000_0010, 4'd0, d), got);
    apply_txn_fast(mk_req(MEM_READ, 8'h11, 32'h0000_0110, 4'd0, 128'd0), got);
    check_output("wrap_read", 176'(got.data), 176'(d));

    apply_txn_slow(mk_req(MEM_INIT, 8'h20, 32'h100, 4'd0,
                          128'h1f1e1d1c_1b1a1918_17161514_13121110), lat);
    check_output("lat_init", 176'(lat), 176'(4));
    check_output("lat_init_msg", 176'(if3.memresp_msg), 176'(mk_resp(3'd2, 8'h20, 4'd0, 128'd0)));
    if3.memresp_rdy = 1'b1;

    apply_txn_slow(mk_req(MEM_READ, 8'h21, 32'h104, 4'd8, 128'd0), lat);
    check_output("lat_read", 176'(lat), 176'(4));
    if3.memreq_msg = mk_req(MEM_WRITE, 8'h22, 32'h100, 4'd0, 128'd0);
    if3.memreq_val = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("stall_val", 176'(if3.memresp_val), 176'(1'b1));
      check_output("stall_msg", 176'(if3.memresp_msg),
                   176'(mk_resp(3'd0, 8'h21, 4'd8, 128'h1b1a1918_17161514)));
      check_output("stall_rdy", 176'(if3.memreq_rdy), 176'(1'b0));
    end
    if3.memreq_val  = 1'b0;
    if3.memresp_rdy = 1'b1;
    @(negedge clk);
    check_output("stall_done_val", 176'(if3.memresp_val), 176'(1'b0));
    check_output("stall_done_rdy", 176'(if3.memreq_rdy), 176'(1'b1));

    if3.memreq_msg = mk_req(MEM_READ, 8'h77, 32'h100, 4'd0, 128'd0);
    if3.memreq_val = 1'b1;
    @(negedge clk);
    if3.memreq_val = 1'b0;
    rst3 = 1'b0;
    #1;
    check_output("midrst_val", 176'(if3.memresp_val), 176'(1'b0));
    check_output("midrst_rdy", 176'(if3.memreq_rdy), 176'(1'b0));
    @(negedge clk);
    rst3 = 1'b1;
    #1;
    check_output("midrst_release_rdy", 176'(if3.memreq_rdy), 176'(1'b1));
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if3.memresp_val) seen = 1'b1;
    end
    check_output("midrst_no_resp", 176'(seen), 176'(1'b0));

    // Line written before the reset must still be readable afterwards.
    apply_txn_slow(mk_req(MEM_READ, 8'h78, 32'h100, 4'd0, 128'd0), lat);
    check_output("persist_read", 176'(if3.memresp_msg),
                 176'(mk_resp(3'd0, 8'h78, 4'd0, 128'h1f1e1d1c_1b1a1918_17161514_13121110)));
    if3.memresp_rdy = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
